dff_pipeline: RTL
=================

// Module: dff_pipeline
//
// PURPOSE
//   Parametrised successor to the single-bit D flip-flop: a DEPTH-stage, WIDTH-bit
//   register pipeline with per-stage valid bits, global stall (EN), synchronous flush
//   and a live occupancy count. Used wherever the design needs a fixed-latency delay
//   line that can be stalled or drained (e.g. aligning datapaths, retiming buses).
//
// PARAMETERS
//   WIDTH  8  data bits per stage (>=1)
//   DEPTH  4  number of stages = latency in enabled cycles (>=1; DEPTH=0 is illegal,
//             elaboration-time $error)
//   OCC_W  $clog2(DEPTH+1)  width of OCCUPANCY (derived localparam, not overridable)
//
// PORTS
//   CLK        in   1      rising-edge clock
//   RST        in   1      asynchronous reset, active-high
//   D          in   WIDTH  input data word
//   VALID_IN   in   1      D carries a valid word this cycle
//   EN         in   1      advance pipeline by one stage; 0 = hold (stall)
//   FLUSH      in   1      synchronous drain of all stages
//   Q          out  WIDTH  data of last stage (stage DEPTH-1)
//   VALID_OUT  out  1      valid bit of last stage
//   OCCUPANCY  out  OCC_W  number of stages currently holding valid words
//   PAR_OUT    out  1      (PIPE_PARITY_EN only) stored even parity of Q
//
// BEHAVIOUR
//   - Reset (RST=1, async, any time incl. mid-stream): every stage data=0, valid=0;
//     Q=0, VALID_OUT=0, OCCUPANCY=0, PAR_OUT=0. Held while RST=1; leaves on first
//     CLK edge after deassertion.
//   - All outputs are registered; no combinational path from inputs to outputs.
//   - Priority per rising edge: FLUSH > EN > hold.
//   - FLUSH=1: all stage data<=0, valid<=0, OCCUPANCY<=0; word on D is dropped,
//     regardless of EN.
//   - EN=1, FLUSH=0: stage[0] <= VALID_IN ? D : 0; valid[0] <= VALID_IN;
//     stage[i] <= stage[i-1], valid[i] <= valid[i-1] for i=1..DEPTH-1.
//     Bubbles (VALID_IN=0) travel as data 0, so VALID_OUT=0 implies Q=0.
//   - EN=0, FLUSH=0: all stages, valids, OCCUPANCY hold; D/VALID_IN ignored.
//   - Latency: a word accepted at edge n (EN=1, VALID_IN=1) appears on Q after the
//     DEPTH-th enabled edge counting n; stalls extend wall-clock latency 1:1.
//   - OCCUPANCY is a registered counter, not a popcount: on enabled edge
//     next = occ + VALID_IN - valid[DEPTH-1]; never exceeds DEPTH, never below 0.
//     Must equal popcount(valid[]) at every cycle (assertion in bench).
//   - Full pipe (OCCUPANCY=DEPTH) with EN=1, VALID_IN=1: oldest word exits, count
//     stays DEPTH. Empty pipe with VALID_IN=0: count stays 0.
//   - DEPTH=1: behaves as a WIDTH-bit D flip-flop with enable, valid and flush.
//
// CONFIGURATION
//   PIPE_PARITY_EN defined: each stage carries one extra bit, loaded as ^D
//     (0 for bubbles) at stage 0 and shifted/held/flushed exactly like data;
//     PAR_OUT = parity bit of last stage. Port PAR_OUT exists.
//   PIPE_PARITY_EN undefined: no parity storage, port PAR_OUT absent; all other
//     behaviour identical.
//
// TESTING (WIDTH=8, DEPTH=4 unless noted)
//   1 Reset: RST=1 mid-stream with 3 valid words -> same cycle Q=0x00, VALID_OUT=0,
//     OCCUPANCY=0; after release, first word out only after 4 enabled edges.
//   2 Stream: EN=1, VALID_IN=1, D=0x11,0x22,0x33,0x44,0x55 on edges 1..5 -> after
//     edge 4 Q=0x11 VALID_OUT=1 OCCUPANCY=4; after edge 5 Q=0x22, OCCUPANCY=4.
//   3 Stall: load 0xA5,0x5A, EN=0 for 3 edges -> Q/VALID_OUT/OCCUPANCY=2 frozen;
//     EN=1 with VALID_IN=0 -> 0xA5 on Q after 2 more enabled edges, OCCUPANCY 2->1.
//   4 Flush vs EN: pipe full, FLUSH=1 and EN=1 and VALID_IN=1 D=0xFF same edge ->
//     next cycle Q=0, VALID_OUT=0, OCCUPANCY=0; 0xFF never appears on Q.
//   5 Bubbles: VALID_IN pattern 1,0,1,0 with D=0x01..0x04 -> Q sequence
//     0x01,0x00,0x03,0x00 with VALID_OUT 1,0,1,0; OCCUPANCY tracks popcount.
//   6 Parity (PIPE_PARITY_EN, DEPTH=1): D=0x07 valid -> PAR_OUT=1; D=0x03 -> 0;
//     rebuild without macro -> compiles, scenarios 1-5 pass unchanged.

Source files
------------

// File: rtl/dff_pipeline.sv
`default_nettype none
// ============================================================================
// Module   : dff_pipeline
// Summary  : DEPTH-stage, WIDTH-bit register delay line. Each stage has a
//            valid bit. The block provides a global stall (EN), a synchronous
//            flush and a registered occupancy counter.
// Options  : Define PIPE_PARITY_EN to add a per-stage even-parity bit and the
//            PAR_OUT port.
// Revision : 1.0 - initial release
// ============================================================================
module dff_pipeline #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] D,
  input  logic             VALID_IN,
  input  logic             EN,
  input  logic             FLUSH,
  output logic [WIDTH-1:0] Q,
  output logic             VALID_OUT,
`ifdef PIPE_PARITY_EN
  output logic             PAR_OUT,
`endif
  output logic [OCC_W-1:0] OCCUPANCY
);

  // A zero-length pipeline has no last stage to drive Q from.
  generate
    if (DEPTH < 1) begin : g_bad_depth
      $error("dff_pipeline: DEPTH must be >= 1");
    end
  endgenerate

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;
`ifdef PIPE_PARITY_EN
  logic [DEPTH-1:0] par_q;
  logic [DEPTH-1:0] par_d;
`endif

  // Next-state logic: flush beats enable, and enable beats hold. Bubbles enter as zero data.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    occ_d   = occ_q;
`ifdef PIPE_PARITY_EN
    par_d   = par_q;
`endif
    if (FLUSH) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_d[i] = '0;
      end
      valid_d = '0;
      occ_d   = '0;
`ifdef PIPE_PARITY_EN
      par_d   = '0;
`endif
    end else if (EN) begin
      data_d[0]  = VALID_IN ? D : '0;
      valid_d[0] = VALID_IN;
`ifdef PIPE_PARITY_EN
      par_d[0]   = VALID_IN & (^D);
`endif
      for (int i = 1; i < DEPTH; i++) begin
        data_d[i]  = data_q[i-1];
        valid_d[i] = valid_q[i-1];
`ifdef PIPE_PARITY_EN
        par_d[i]   = par_q[i-1];
`endif
      end
      // The counter cannot wrap. A word can only leave when occ_q >= 1, and a
      // word cannot enter a full pipe unless another word leaves at the same time.
      occ_d = occ_q + OCC_W'(VALID_IN) - OCC_W'(valid_q[DEPTH-1]);
    end
  end

  // Stage registers and the occupancy counter, cleared asynchronously.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
      valid_q <= '0;
      occ_q   <= '0;
`ifdef PIPE_PARITY_EN
      par_q   <= '0;
`endif
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
      end
      valid_q <= valid_d;
      occ_q   <= occ_d;
`ifdef PIPE_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign Q         = data_q[DEPTH-1];
  assign VALID_OUT = valid_q[DEPTH-1];
  assign OCCUPANCY = occ_q;
`ifdef PIPE_PARITY_EN
  assign PAR_OUT   = par_q[DEPTH-1];
`endif

endmodule
`default_nettype wire
